cra_seq: RTL

Parametrised multi-cycle ripple-carry adder/subtractor. Adds two WIDTH-bit operands one CHUNK-bit slice per clock, LSB slice first, carrying between slices in a register. It generalises the 8-bit combinational ripple chain to arbitrary width and trades latency for a short critical path of CHUNK full-adder stages. It also adds subtract mode, signed-overflow detection and a start/done handshake. It sits in the datapath wherever wide additions must meet timing without a full-width carry chain.

---
 rtl/cra_seq_if.sv | 27 ++
 rtl/cra_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/cra_seq_if.sv
// cra_seq_if: start/operand request and busy/done/result response of the sequential adder.
// Latency: none, plain wiring bundle.
// Backpressure: none carried here; the requester watches busy/done.
interface cra_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cra_seq.sv
// cra_seq: multi-cycle ripple-carry adder/subtractor, CHUNK bits per cycle, LSB slice first.
// Latency: WIDTH/CHUNK cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.
module cra_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    cra_seq_if.slave io
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic [31:0]      sh;
    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic [CHUNK:0]   sres;
    logic             msb_cin;
    logic [WIDTH-1:0] slice_mask;
    logic [WIDTH-1:0] acc_nxt;

    // One CHUNK-wide ripple slice selected by the counter, merged into the accumulator image.
    always_comb begin
        sh         = 32'(cnt) * 32'(CHUNK);
        sa         = CHUNK'(opa >> sh);
        sb         = CHUNK'(opb >> sh);
        sres       = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry};
        // Carry into the top bit of the slice; only meaningful on the final slice (bit WIDTH-1).
        msb_cin    = sa[CHUNK-1] ^ sb[CHUNK-1] ^ sres[CHUNK-1];
        slice_mask = WIDTH'({CHUNK{1'b1}}) << sh;
        acc_nxt    = (acc & ~slice_mask) | (WIDTH'(sres[CHUNK-1:0]) << sh);
    end

    // Operation sequencing: capture on start, one slice per RUN cycle, publish results on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        // Subtraction is a + ~b + 1, so cin is irrelevant in that mode.
                        opa   <= io.a;
                        opb   <= io.sub ? ~io.b : io.b;
                        carry <= io.sub ? 1'b1 : io.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= sres[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= acc_nxt;
                        cout_q <= sres[CHUNK];
                        ovf_q  <= msb_cin ^ sres[CHUNK];
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.busy = (state == RUN);
    assign io.done = done_q;
    assign io.sum  = sum_q;
    assign io.cout = cout_q;
    assign io.ovf  = ovf_q;
endmodule
